// File: rtl/command_executor_pkg.sv
// Shared encodings for the command executor: scheduler opcodes, memory command codes,
// FSM states, open-row lookup results and the timing-counter sizing helper.
package command_executor_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_REFRESH = 2'd2,
    OP_RSVD    = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    MC_NOP  = 3'd0,
    MC_ACT  = 3'd1,
    MC_RD   = 3'd2,
    MC_WR   = 3'd3,
    MC_PRE  = 3'd4,
    MC_PREA = 3'd5,
    MC_REF  = 3'd6
  } mem_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ACT,
    ST_ACCESS,
    ST_PREA,
    ST_REF,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    LK_CLOSED,
    LK_HIT,
    LK_MISS
  } lookup_e;

  function automatic int max_timing(input int a, input int b, input int c,
                                    input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/command_executor_bank_row_table.sv
// Per-bank open-row tracker: combinational lookup of the offered command against the
// table, updated by ACT (open), PRE (close) and PREA/REF (close all).
module bank_row_table
  import command_executor_pkg::*;
#(
  parameter int NBANKS = 4,
  parameter int ROW_W  = 13,
  localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BANK_W-1:0] lk_bank_i,
  input  logic [ROW_W-1:0]  lk_row_i,
  output lookup_e           lk_o,
  input  logic              set_i,
  input  logic              close_i,
  input  logic              clear_i,
  input  logic [BANK_W-1:0] upd_bank_i,
  input  logic [ROW_W-1:0]  set_row_i
);

  logic [NBANKS-1:0] open_q;
  logic [ROW_W-1:0]  row_q [NBANKS];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      open_q <= '0;
    end else if (set_i) begin
      open_q[upd_bank_i] <= 1'b1;
    end else if (close_i) begin
      open_q[upd_bank_i] <= 1'b0;
    end
  end

  // Row contents only matter while the open bit is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (set_i) begin
      row_q[upd_bank_i] <= set_row_i;
    end
  end

  always_comb begin
    lk_o = LK_CLOSED;
    if (open_q[lk_bank_i]) begin
      lk_o = (row_q[lk_bank_i] == lk_row_i) ? LK_HIT : LK_MISS;
    end
  end

endmodule

// File: rtl/command_executor.sv
// Scheduler-facing command executor: accepts one command per handshake and expands it into a
// timed PRE/ACT/RD/WR/PREA/REF sequence, pulsing cmd_executed when the last window closes.
module command_executor
  import command_executor_pkg::*;
#(
  parameter int NBANKS = 4,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 10,
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_CL   = 4,
  parameter int T_WR   = 5,
  parameter int T_RFC  = 8,
  localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic [COL_W-1:0]  cmd_col,
  output logic              cmd_executed,
  output logic              mem_cmd_valid,
  output logic [2:0]        mem_cmd,
  output logic [BANK_W-1:0] mem_bank,
  output logic [ROW_W-1:0]  mem_addr
);

  localparam int T_MAX = max_timing(T_RCD, T_RP, T_CL, T_WR, T_RFC);
  localparam int CNT_W = $clog2(T_MAX + 1);

  state_e            state_q, state_d, nxt_q, nxt_d, issue_tgt;
  logic [CNT_W-1:0]  cnt_q, cnt_d, t_load;
  logic              issuing, accept;
  cmd_op_e           op_q;
  logic [BANK_W-1:0] bank_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  lookup_e           lk;
  logic              ready_q, ready_d, exec_q, exec_d, mvalid_q, mvalid_d;
  mem_cmd_e          mcmd_q, mcmd_d;
  logic [BANK_W-1:0] mbank_q, mbank_d;
  logic [ROW_W-1:0]  maddr_q, maddr_d;
  logic              tbl_set, tbl_close, tbl_clear;

  assign accept = cmd_valid && ready_q;

  // Lookup runs on the live inputs so the first state is chosen at the accept edge.
  bank_row_table #(
    .NBANKS (NBANKS),
    .ROW_W  (ROW_W)
  ) u_table (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .lk_bank_i  (cmd_bank),
    .lk_row_i   (cmd_row),
    .lk_o       (lk),
    .set_i      (tbl_set),
    .close_i    (tbl_close),
    .clear_i    (tbl_clear),
    .upd_bank_i (bank_q),
    .set_row_i  (row_q)
  );

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    cnt_d     = cnt_q;
    issuing   = 1'b0;
    issue_tgt = ST_DONE;
    t_load    = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op_e'(cmd_op))
            OP_READ, OP_WRITE: begin
              if (lk == LK_HIT)         state_d = ST_ACCESS;
              else if (lk == LK_CLOSED) state_d = ST_ACT;
              else                      state_d = ST_PRE;
            end
            OP_REFRESH: state_d = ST_PREA;
            default:    state_d = ST_DONE;
          endcase
        end
      end
      ST_PRE: begin
        issuing = 1'b1; issue_tgt = ST_ACT; t_load = CNT_W'(T_RP - 1);
      end
      ST_PREA: begin
        issuing = 1'b1; issue_tgt = ST_REF; t_load = CNT_W'(T_RP - 1);
      end
      ST_ACT: begin
        issuing = 1'b1; issue_tgt = ST_ACCESS; t_load = CNT_W'(T_RCD - 1);
      end
      ST_ACCESS: begin
        issuing   = 1'b1;
        issue_tgt = ST_DONE;
        t_load    = (op_q == OP_WRITE) ? CNT_W'(T_WR - 1) : CNT_W'(T_CL - 1);
      end
      ST_REF: begin
        issuing = 1'b1; issue_tgt = ST_DONE; t_load = CNT_W'(T_RFC - 1);
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = nxt_q;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A window of one cycle skips WAIT entirely.
    if (issuing) begin
      if (t_load == '0) begin
        state_d = issue_tgt;
      end else begin
        state_d = ST_WAIT;
        nxt_d   = issue_tgt;
        cnt_d   = t_load;
      end
    end
  end

  always_comb begin
    ready_d   = (state_q == ST_IDLE) && !accept;
    exec_d    = (state_q == ST_DONE);
    mvalid_d  = 1'b0;
    mcmd_d    = MC_NOP;
    mbank_d   = '0;
    maddr_d   = '0;
    tbl_set   = 1'b0;
    tbl_close = 1'b0;
    tbl_clear = 1'b0;
    case (state_q)
      ST_PRE: begin
        mvalid_d = 1'b1; mcmd_d = MC_PRE; mbank_d = bank_q; tbl_close = 1'b1;
      end
      ST_ACT: begin
        mvalid_d = 1'b1; mcmd_d = MC_ACT; mbank_d = bank_q; maddr_d = row_q; tbl_set = 1'b1;
      end
      ST_ACCESS: begin
        mvalid_d = 1'b1;
        mcmd_d   = (op_q == OP_WRITE) ? MC_WR : MC_RD;
        mbank_d  = bank_q;
        maddr_d  = ROW_W'(col_q);
      end
      ST_PREA: begin
        mvalid_d = 1'b1; mcmd_d = MC_PREA; tbl_clear = 1'b1;
      end
      ST_REF: begin
        mvalid_d = 1'b1; mcmd_d = MC_REF; tbl_clear = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      nxt_q    <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      exec_q   <= 1'b0;
      mvalid_q <= 1'b0;
      mcmd_q   <= MC_NOP;
      mbank_q  <= '0;
      maddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      nxt_q    <= nxt_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      exec_q   <= exec_d;
      mvalid_q <= mvalid_d;
      mcmd_q   <= mcmd_d;
      mbank_q  <= mbank_d;
      maddr_q  <= maddr_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      op_q   <= cmd_op_e'(cmd_op);
      bank_q <= cmd_bank;
      row_q  <= cmd_row;
      col_q  <= cmd_col;
    end
  end

  assign cmd_ready     = ready_q;
  assign cmd_executed  = exec_q;
  assign mem_cmd_valid = mvalid_q;
  assign mem_cmd       = mcmd_q;
  assign mem_bank      = mbank_q;
  assign mem_addr      = maddr_q;

endmodule

// File: tb/tb_command_executor.sv
// Bench for command_executor: table of commands with expected path and completion cycle,
// expanded into a timed event scoreboard, plus hand sequences for reserved-op and mid-op reset.
module tb_command_executor;

  localparam int T_RCD = 3;
  localparam int T_RP  = 3;
  localparam int T_CL  = 4;
  localparam int T_WR  = 5;
  localparam int T_RFC = 8;

  localparam logic [2:0] C_ACT  = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_PREA = 3'd5;
  localparam logic [2:0] C_REF  = 3'd6;
  localparam logic [2:0] C_EXEC = 3'd7;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_bank = 2'd0;
  logic [12:0] cmd_row = '0;
  logic [9:0]  cmd_col = '0;
  logic        cmd_executed;
  logic        mem_cmd_valid;
  logic [2:0]  mem_cmd;
  logic [1:0]  mem_bank;
  logic [12:0] mem_addr;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exec_cnt = 0;
  logic exec_seen = 1'b0;

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
  } evt_t;
  evt_t sb[$];

  typedef enum {P_HIT, P_CLOSED, P_MISS, P_REF, P_NOP} path_e;
  typedef struct {
    logic [1:0]  op;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
    path_e       path;
    int          exec_off;
  } vec_t;

  command_executor #(
    .NBANKS (4), .ROW_W (13), .COL_W (10),
    .T_RCD (T_RCD), .T_RP (T_RP), .T_CL (T_CL), .T_WR (T_WR), .T_RFC (T_RFC)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_bank      (cmd_bank),
    .cmd_row       (cmd_row),
    .cmd_col       (cmd_col),
    .cmd_executed  (cmd_executed),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd       (mem_cmd),
    .mem_bank      (mem_bank),
    .mem_addr      (mem_addr)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] cmd, input logic [1:0] b,
                      input logic [12:0] a);
    evt_t e;
    e.cyc = c; e.cmd = cmd; e.bank = b; e.addr = a;
    sb.push_back(e);
  endtask

  task automatic check_evt(input logic [2:0] cmd, input logic [1:0] b, input logic [12:0] a);
    evt_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got cmd %0d bank %0d addr %0h at cycle %0d, required none",
               cmd, b, a, cyc);
    end else begin
      e = sb.pop_front();
      if (e.cyc != cyc || e.cmd !== cmd || e.bank !== b || e.addr !== a) begin
        errors++;
        $display("FAIL event: got cmd %0d bank %0d addr %0h at cycle %0d, required cmd %0d bank %0d addr %0h at cycle %0d",
                 cmd, b, a, cyc, e.cmd, e.bank, e.addr, e.cyc);
      end
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT presented this cycle.
  task automatic tick();
    @(negedge sys_clk);
    exec_seen = 1'b0;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      errors++;
      $display("FAIL missing_event: got nothing, required cmd %0d bank %0d addr %0h at cycle %0d",
               sb[0].cmd, sb[0].bank, sb[0].addr, sb[0].cyc);
      sb.delete(0);
    end
    if (mem_cmd_valid) check_evt(mem_cmd, mem_bank, mem_addr);
    else chk("idle_bus", {14'd0, mem_cmd, mem_bank, mem_addr}, 0);
    if (cmd_executed) begin
      exec_seen = 1'b1;
      exec_cnt++;
      check_evt(C_EXEC, 2'd0, 13'd0);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("ready_timeout", {31'd0, cmd_ready}, 1);
  endtask

  task automatic expand(input vec_t v, input int acc);
    int t;
    logic [2:0] acc_cmd;
    t = acc + 1;
    acc_cmd = (v.op == 2'd1) ? C_WR : C_RD;
    case (v.path)
      P_HIT: push(t, acc_cmd, v.bank, {3'b0, v.col});
      P_CLOSED: begin
        push(t, C_ACT, v.bank, v.row);
        push(t + T_RCD, acc_cmd, v.bank, {3'b0, v.col});
      end
      P_MISS: begin
        push(t, C_PRE, v.bank, 13'd0);
        push(t + T_RP, C_ACT, v.bank, v.row);
        push(t + T_RP + T_RCD, acc_cmd, v.bank, {3'b0, v.col});
      end
      P_REF: begin
        push(t, C_PREA, 2'd0, 13'd0);
        push(t + T_RP, C_REF, 2'd0, 13'd0);
      end
      default: ;
    endcase
    push(acc + v.exec_off, C_EXEC, 2'd0, 13'd0);
  endtask

  task automatic run_cmd(input vec_t v);
    int acc, n;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op = v.op; cmd_bank = v.bank; cmd_row = v.row; cmd_col = v.col;
    acc = cyc + 1;
    expand(v, acc);
    tick();
    chk("busy_ready", {31'd0, cmd_ready}, 0);
    // Keep offering a different command while busy; it must not be taken.
    cmd_op = 2'd1; cmd_bank = v.bank + 2'd1; cmd_row = v.row ^ 13'h1555;
    n = 0;
    while (!exec_seen && n < 40) begin
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    chk("exec_timeout", {31'd0, exec_seen}, 1);
    chk("ready_at_done", {31'd0, cmd_ready}, 0);
    tick();
    chk("ready_after_done", {31'd0, cmd_ready}, 1);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    vec_t vecs[11];
    int   acc, ex0;
    vecs[0]  = '{2'd0, 2'd0, 13'd5,    10'd9,    P_CLOSED, 8};
    vecs[1]  = '{2'd0, 2'd0, 13'd5,    10'd2,    P_HIT,    5};
    vecs[2]  = '{2'd1, 2'd0, 13'd7,    10'd3,    P_MISS,   12};
    vecs[3]  = '{2'd0, 2'd1, 13'd20,   10'd1,    P_CLOSED, 8};
    vecs[4]  = '{2'd2, 2'd1, 13'd20,   10'd0,    P_REF,    12};
    vecs[5]  = '{2'd0, 2'd1, 13'd20,   10'd4,    P_CLOSED, 8};
    vecs[6]  = '{2'd3, 2'd2, 13'd1,    10'd1,    P_NOP,    1};
    vecs[7]  = '{2'd1, 2'd1, 13'd20,   10'd1023, P_HIT,    6};
    vecs[8]  = '{2'd0, 2'd3, 13'd8191, 10'd0,    P_CLOSED, 8};
    vecs[9]  = '{2'd1, 2'd3, 13'd0,    10'd5,    P_MISS,   12};
    vecs[10] = '{2'd0, 2'd0, 13'd7,    10'd0,    P_CLOSED, 8};

    sys_rst = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {13'd0, cmd_ready, cmd_executed, mem_cmd_valid, mem_cmd, mem_bank, mem_addr}, 0);
    sys_rst = 1'b0;
    tick();
    chk("ready_after_reset", {31'd0, cmd_ready}, 1);

    for (int i = 0; i < 11; i++) run_cmd(vecs[i]);

    // Reserved op held valid: completes after one cycle, is re-accepted once ready returns.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_bank = 2'd2; cmd_row = 13'd3; cmd_col = 10'd3;
    acc = cyc + 1;
    push(acc + 1, C_EXEC, 2'd0, 13'd0);
    push(acc + 4, C_EXEC, 2'd0, 13'd0);
    tick();
    tick();
    chk("rsvd_ready_busy", {31'd0, cmd_ready}, 0);
    tick();
    chk("rsvd_ready_back", {31'd0, cmd_ready}, 1);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("rsvd_events", sb.size(), 0);
    sb.delete();

    // Reset during a row-miss WRITE (bank0 holds row 7): aborts without a completion pulse.
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_bank = 2'd0; cmd_row = 13'd9; cmd_col = 10'd3;
    acc = cyc + 1;
    push(acc + 1, C_PRE, 2'd0, 13'd0);
    push(acc + 1 + T_RP, C_ACT, 2'd0, 13'd9);
    tick();
    cmd_valid = 1'b0;
    while (cyc < acc + 5) tick();
    sys_rst = 1'b1;
    ex0 = exec_cnt;
    tick();
    chk("rst_outputs", {13'd0, cmd_ready, cmd_executed, mem_cmd_valid, mem_cmd, mem_bank, mem_addr}, 0);
    sys_rst = 1'b0;
    tick();
    chk("rst_ready_back", {31'd0, cmd_ready}, 1);
    repeat (10) tick();
    chk("rst_no_exec", exec_cnt - ex0, 0);
    chk("rst_events", sb.size(), 0);
    sb.delete();

    // Table was cleared by reset: bank0 row 9 must be re-activated.
    run_cmd('{2'd0, 2'd0, 13'd9, 10'd0, P_CLOSED, 8});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
